// File: rtl/uart_pkg.sv
// Shared constants for the UART receive buffer: default word/depth sizes and the level-width helper.
// Purely combinational declarations; no timing or backpressure of its own.
package uart_pkg;

  localparam int DefWdata = 8;
  localparam int DefDepth = 16;

  // Level counter must represent 0..Depth inclusive, hence one bit beyond the pointer width.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Depth x Wdata storage with a synchronous write port and an asynchronous (show-ahead) read port.
// Write lands at the clock edge; read is combinational; no flow control and no reset.
module uart_fifo_ram
  import uart_pkg::*;
#(
  parameter int Wdata = DefWdata,
  parameter int Depth = DefDepth
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] waddr_i,
  input  logic [Wdata-1:0]         wdata_i,
  input  logic [$clog2(Depth)-1:0] raddr_i,
  output logic [Wdata-1:0]         rdata_o
);

  logic [Wdata-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead RX FIFO: pushes on the receiver strobe, words visible the cycle after the push; drops and flags overrun when full.
// Pop on rvalid & rready; optional idle timeout built only with UART_RXFIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int Wdata    = DefWdata,
  parameter int Depth    = DefDepth,
  parameter int Thresh   = 8,
  parameter int Ntimeout = 40000
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [Wdata-1:0]            din_i,
  input  logic                        dint_i,
  output logic [Wdata-1:0]            rdata_o,
  output logic                        rvalid_o,
  input  logic                        rready_i,
  output logic [level_w(Depth)-1:0]   level_o,
  output logic                        full_o,
  output logic                        irq_o,
  output logic                        ovr_o,
  input  logic                        ovr_clr_i,
  output logic                        tout_o
);

  localparam int PW = $clog2(Depth);
  localparam int LW = level_w(Depth);

  if (Depth < 2 || Depth > 256 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: Depth must be a power of two in 2..256");
  end
  if (Thresh < 1 || Thresh > Depth) begin : g_bad_thresh
    $error("uart_rx_fifo: Thresh must be in 1..Depth");
  end
  if (Ntimeout < 1) begin : g_bad_ntimeout
    $error("uart_rx_fifo: Ntimeout must be at least 1");
  end

  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovr_q, ovr_d;
  logic          push, pop, drop;

  assign rvalid_o = (level_q != '0);
  assign full_o   = (level_q == LW'(Depth));
  assign irq_o    = (level_q >= LW'(Thresh));
  assign level_o  = level_q;
  assign ovr_o    = ovr_q;

  // A full FIFO still accepts a push when the same cycle pops, so only a non-popping full push drops.
  assign pop  = rvalid_o & rready_i;
  assign push = dint_i & (~full_o | pop);
  assign drop = dint_i & full_o & ~pop;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    ovr_d   = ovr_q;
    if (push) wp_d = wp_q + 1'b1;
    if (pop)  rp_d = rp_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    if (ovr_clr_i) ovr_d = 1'b0;
    if (drop)      ovr_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      ovr_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
      ovr_q   <= ovr_d;
    end
  end

  uart_fifo_ram #(
    .Wdata(Wdata),
    .Depth(Depth)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (push),
    .waddr_i(wp_q),
    .wdata_i(din_i),
    .raddr_i(rp_q),
    .rdata_o(rdata_o)
  );

`ifdef UART_RXFIFO_TIMEOUT_EN
  localparam int TW = $clog2(Ntimeout + 1);

  logic [TW-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (push || pop || level_q == '0) idle_d = '0;
    else if (idle_q != TW'(Ntimeout)) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idle_q <= '0;
    else         idle_q <= idle_d;
  end

  assign tout_o = (idle_q == TW'(Ntimeout)) & rvalid_o;
`else
  assign tout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a vector table for single-cycle behaviour plus hand sequences for fill, overrun and timeout.
module tb_uart_rx_fifo;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int TH = 8;
  localparam int NT = 100;
  localparam int LW = 5;
`ifdef UART_RXFIFO_TIMEOUT_EN
  localparam logic TOEN = 1'b1;
`else
  localparam logic TOEN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  din;
  logic          dint;
  logic [W-1:0]  rdata;
  logic          rvalid;
  logic          rready;
  logic [LW-1:0] level;
  logic          full;
  logic          irq;
  logic          ovr;
  logic          ovr_clr;
  logic          tout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .Wdata(W), .Depth(D), .Thresh(TH), .Ntimeout(NT)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .din_i    (din),
    .dint_i   (dint),
    .rdata_o  (rdata),
    .rvalid_o (rvalid),
    .rready_i (rready),
    .level_o  (level),
    .full_o   (full),
    .irq_o    (irq),
    .ovr_o    (ovr),
    .ovr_clr_i(ovr_clr),
    .tout_o   (tout)
  );

  typedef struct {
    logic         dint;
    logic [W-1:0] din;
    logic         rready;
    logic         clr;
    logic         rv;
    logic [W-1:0] rd;
    int           lvl;
    logic         ovr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Expected full/irq follow from the expected level; rdata only matters while valid.
  task automatic chk_all(input string tag, input logic rv, input logic [W-1:0] rd,
                         input int lvl, input logic o);
    chk({tag, " rvalid"}, 32'(rvalid), 32'(rv));
    chk({tag, " level"},  32'(level),  32'(lvl));
    chk({tag, " full"},   32'(full),   32'(lvl == D));
    chk({tag, " irq"},    32'(irq),    32'(lvl >= TH));
    chk({tag, " ovr"},    32'(ovr),    32'(o));
    chk({tag, " tout"},   32'(tout),   32'(0));
    if (rv) chk({tag, " rdata"}, 32'(rdata), 32'(rd));
  endtask

  task automatic step(input logic d_v, input logic [W-1:0] d, input logic rr, input logic clr);
    dint    = d_v;
    din     = d;
    rready  = rr;
    ovr_clr = clr;
    @(posedge clk);
    #1;
    dint    = 1'b0;
    rready  = 1'b0;
    ovr_clr = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    vecs[2] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 1, 1'b0};
    vecs[3] = '{1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 8'h3C, 2, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h7E, 1, 1'b0};
    vecs[5] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b0};

    rst_n = 1'b0; din = '0; dint = 1'b0; rready = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 8'h00, 0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].dint, vecs[i].din, vecs[i].rready, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].rv, vecs[i].rd, vecs[i].lvl, vecs[i].ovr);
    end

    // Fill to full, overrun with 0xFF, then drain in order.
    for (int i = 0; i < D; i++) begin
      step(1'b1, W'(i), 1'b0, 1'b0);
      chk_all($sformatf("fill%0d", i), 1'b1, 8'h00, i + 1, 1'b0);
    end
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk_all("overrun", 1'b1, 8'h00, D, 1'b1);
    for (int i = 0; i < D; i++) begin
      chk($sformatf("drain%0d head", i), 32'(rdata), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("drain%0d level", i), 32'(level), 32'(D - 1 - i));
    end
    chk_all("drained", 1'b0, 8'h00, 0, 1'b1);

    // Overrun set beats a simultaneous clear; a lone clear releases it.
    for (int i = 0; i < D; i++) step(1'b1, W'(8'h20 + i), 1'b0, 1'b0);
    chk_all("refill", 1'b1, 8'h20, D, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    chk_all("clr+drop", 1'b1, 8'h20, D, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_all("clr", 1'b1, 8'h20, D, 1'b0);

    // Full with push and pop together keeps the level and accepts the word.
    step(1'b1, 8'h55, 1'b1, 1'b0);
    chk_all("full push+pop", 1'b1, 8'h21, D, 1'b0);
    for (int i = 0; i < D; i++) begin
      chk($sformatf("drain2_%0d head", i), 32'(rdata), (i == D - 1) ? 32'h55 : 32'(8'h21 + i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk_all("drained2", 1'b0, 8'h00, 0, 1'b0);

    // Asynchronous reset mid-operation clears contents without a clock edge.
    step(1'b1, 8'h9A, 1'b0, 1'b0);
    step(1'b1, 8'h9B, 1'b0, 1'b0);
    chk_all("pre-reset", 1'b1, 8'h9A, 2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rvalid", 32'(rvalid), 32'(0));
    chk("async rst level",  32'(level),  32'(0));
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle timeout: fires NT idle clocks after the last push/pop, only when built in.
    for (int i = 0; i < 3; i++) step(1'b1, W'(8'h40 + i), 1'b0, 1'b0);
    repeat (NT - 1) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tout before limit", 32'(tout), 32'(0));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tout at limit", 32'(tout), 32'(TOEN));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("tout after pop", 32'(tout), 32'(0));
    chk("tout pop level", 32'(level), 32'(2));
    repeat (NT - 1) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tout restart before", 32'(tout), 32'(0));
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("tout restart at limit", 32'(tout), 32'(TOEN));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_all("tout emptied", 1'b0, 8'h00, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer sitting directly downstream of the UART receiver. Captures each received word on the receiver's one-cycle completion strobe and stores it in a show-ahead FIFO. Presents the words to the bus/CPU side through a valid/ready read port. Reports fill level, a threshold interrupt and a sticky overrun flag.

Parameters:
Wdata, 8, data word width; must match the receiver's data width.
Depth, 16, FIFO entries; power of two, 2..256.
Thresh, 8, IRQ asserts while LEVEL >= Thresh; 1..Depth.
Ntimeout, 40000, idle clocks before TOUT; only used with the optional feature.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
DIN  in  Wdata  received word, connected to the receiver DOUT.
DINT  in  1  push strobe, connected to the receiver INT; each high cycle is one push.
RDATA  out  Wdata  head-of-FIFO word; valid only while RVALID=1.
RVALID  out  1  FIFO non-empty.
RREADY  in  1  consumer accepts the word; pop occurs when RVALID & RREADY.
LEVEL  out  $clog2(Depth)+1  current entry count, 0..Depth.
FULL  out  1  LEVEL == Depth.
IRQ  out  1  LEVEL >= Thresh, registered.
OVR  out  1  sticky overrun flag.
OVR_CLR  in  1  clears OVR.
TOUT  out  1  idle timeout; tied 0 unless the optional feature is enabled.

Behaviour:
- Reset (RST_N low, asynchronous): write pointer, read pointer and LEVEL go to 0. RVALID, FULL, IRQ, OVR and TOUT go to 0. Memory contents are not reset.
- Pointers are $clog2(Depth) bits and wrap naturally modulo Depth. LEVEL is tracked in a separate counter.
- Push: on a cycle with DINT=1 and no drop, DIN is written to mem[wp] and wp increments.
- Pop: on a cycle with RVALID & RREADY, rp increments.
- LEVEL update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: DINT at edge n gives RVALID=1 and RDATA=DIN after edge n. RDATA is a combinational read of mem[rp] (show-ahead).
- Empty with DINT and RREADY in the same cycle: no pop, because RVALID was 0; the push is accepted.
- Full with DINT and no pop: the word is dropped, pointers are unchanged, and OVR is set at that edge.
- Full with DINT and a pop in the same cycle: the push is accepted; LEVEL stays at Depth and OVR is not set.
- OVR remains set until an OVR_CLR cycle. If OVR_CLR and a new overrun occur in the same cycle, set wins.
- FULL, RVALID and IRQ are derived from the registered LEVEL; they change in the same cycle as LEVEL.
- RREADY while RVALID=0 is ignored.
- Reset mid-operation discards all contents; RVALID drops immediately (asynchronous).

Optional Feature:
Macro UART_RXFIFO_TIMEOUT_EN.
- Defined:
  - An idle counter of $clog2(Ntimeout+1) bits resets to 0 on any push, any pop, or LEVEL==0.
  - Otherwise it increments, saturating at Ntimeout.
  - TOUT=1 while the counter equals Ntimeout and LEVEL>0.
  - TOUT clears on the edge of the next push or pop, or when the FIFO is emptied.
  - Purpose: flush a partial buffer that sits below Thresh.
- Not defined: no counter is built and TOUT is constant 0.

Decomposition:
- Shared package uart_pkg:
  - default Wdata=8 and Depth=16 constants;
  - the LEVEL width function ($clog2(Depth)+1) as a constant expression.
- One sub-module, uart_fifo_ram:
  - Depth x Wdata storage;
  - synchronous write port (we, waddr, wdata);
  - asynchronous read port (raddr -> rdata);
  - no reset.
- Pointer, level and flag control stay in uart_rx_fifo.

Test Plan:
- Reset, then push 0xA5 via one DINT pulse -> next cycle RVALID=1, RDATA=0xA5, LEVEL=1. Then RREADY one cycle -> RVALID=0, LEVEL=0.
- Push 0x00..0x0F (16 words) with RREADY=0 -> FULL=1, LEVEL=16, IRQ went high after the 8th push. Then push 0xFF -> OVR=1, LEVEL=16. Drain -> reads 0x00..0x0F in order and 0xFF is never seen.
- FIFO full, DINT=1 with DIN=0x55 and RREADY=1 in the same cycle -> LEVEL stays 16, OVR stays 0, 0x55 is read last.
- Empty, DINT=1 with DIN=0x3C and RREADY=1 in the same cycle -> no pop, LEVEL=1, RDATA=0x3C.
- OVR=1; assert OVR_CLR in the same cycle as another full-drop -> OVR stays 1. Assert OVR_CLR alone -> OVR=0.
- With UART_RXFIFO_TIMEOUT_EN and Ntimeout=100: push 3 words, then idle -> TOUT=1 after 100 idle clocks. Pop one -> TOUT=0 and the count restarts. Without the macro -> TOUT stays 0 throughout.
